// File: rtl/uart_rx_os_if.sv
// Receiver-side bundle for uart_rx_os: serial line in, show-ahead word FIFO out.
// master = receiver, slave = line driver / word consumer.
interface uart_rx_os_if #(
   parameter int WIDTH      = 64,
   parameter int FIFO_DEPTH = 4
);
   logic                        rx_in;
   logic                        rx_ready;
   logic                        rx_valid;
   logic [WIDTH-2:0]            rx_data;
   logic                        parity_error;
   logic                        framing_error;
   logic                        overflow;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   modport master (
      input  rx_in, rx_ready,
      output rx_valid, rx_data, parity_error, framing_error, overflow, fifo_count
   );

   modport slave (
      output rx_in, rx_ready,
      input  rx_valid, rx_data, parity_error, framing_error, overflow, fifo_count
   );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver (start 0, LSB-first WIDTH bits with odd parity MSB, stop 1)
// feeding a show-ahead output FIFO. Define UART_RX_MAJORITY_EN for 3-sample bit voting.
module uart_rx_os #(
   parameter int WIDTH      = 64,
   parameter int OVERSAMPLE = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk_rx,
   input  logic         reset,
   uart_rx_os_if.master bus
);
   localparam int M  = OVERSAMPLE / 2;
   localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BW = $clog2(WIDTH);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   logic             rx_d1_q, rx_d2_q;
   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [BW-1:0]    bit_q;
   logic [WIDTH-1:0] frame_q;
   logic             ferr_q, ovf_q;
   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] head;
   logic             sample, decide, full, pop, push;

`ifdef UART_RX_MAJORITY_EN
   localparam bit VOTE = (OVERSAMPLE >= 4);
   localparam int DP   = VOTE ? M + 1 : M;
   localparam int MA   = (M > 0) ? M - 1 : 0;

   logic vote_a_q, vote_b_q;

   // The third vote is the live rx_d2 at the decision point M+1.
   always_ff @(posedge clk_rx) begin
      if (cnt_q == CW'(MA)) vote_a_q <= rx_d2_q;
      if (cnt_q == CW'(M))  vote_b_q <= rx_d2_q;
   end

   assign sample = VOTE ? ((vote_a_q & vote_b_q) | (vote_a_q & rx_d2_q) | (vote_b_q & rx_d2_q))
                        : rx_d2_q;
`else
   localparam int DP = M;
   assign sample = rx_d2_q;
`endif

   assign decide  = (cnt_q == CW'(DP));
   assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
   assign pop     = (count_q != '0) && bus.rx_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still takes the frame.
   assign push    = (state_q == STOP) && decide && sample && (!full || pop);
   assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

   always_ff @(posedge clk_rx) begin
      if (reset) begin
         rx_d1_q <= 1'b1;
         rx_d2_q <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         ferr_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         rx_d1_q <= bus.rx_in;
         rx_d2_q <= rx_d1_q;
         ferr_q  <= 1'b0;
         ovf_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rx_d2_q) begin
                  bit_q <= '0;
                  if (OVERSAMPLE == 1) begin
                     state_q <= DATA;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= START;
                     cnt_q   <= CW'(1);
                  end
               end
            end
            START: begin
               if (decide && sample) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == CW'(OVERSAMPLE - 1)) begin
                  state_q <= DATA;
                  cnt_q   <= '0;
                  bit_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DATA: begin
               if (cnt_q == CW'(OVERSAMPLE - 1)) begin
                  cnt_q <= '0;
                  if (bit_q == BW'(WIDTH - 1)) state_q <= STOP;
                  else                         bit_q   <= bit_q + BW'(1);
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            STOP: begin
               // Leave at the decision point so a zero-gap next start is caught.
               if (decide) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  if (!sample)         ferr_q <= 1'b1;
                  else if (full && !pop) ovf_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_rx) begin
      if (state_q == DATA && decide) frame_q[bit_q] <= sample;
   end

   always_ff @(posedge clk_rx) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + AW'(1);
         if (pop)  rd_q <= rd_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Entry = {parity flag, payload}; flag set when the frame has even ones count.
   always_ff @(posedge clk_rx) begin
      if (push) mem_q[wr_q] <= {~^frame_q, frame_q[WIDTH-2:0]};
   end

   assign head              = mem_q[rd_q];
   assign bus.rx_valid      = (count_q != '0);
   assign bus.rx_data       = bus.rx_valid ? head[WIDTH-2:0] : '0;
   assign bus.parity_error  = bus.rx_valid & head[WIDTH-1];
   assign bus.framing_error = ferr_q;
   assign bus.overflow      = ovf_q;
   assign bus.fifo_count    = count_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// Randomised scoreboard bench for uart_rx_os: frames are modelled at send time,
// a monitor pops the expected queue on every accepted output word.
`timescale 1ns/1ps
module tb_uart_rx_os;
   localparam int W     = 64;
   localparam int OS    = 4;
   localparam int DEPTH = 4;

   logic clk_rx = 1'b0;
   logic reset  = 1'b1;
   always #5 clk_rx = ~clk_rx;

   uart_rx_os_if #(.WIDTH(W), .FIFO_DEPTH(DEPTH)) bus  ();
   uart_rx_os_if #(.WIDTH(W), .FIFO_DEPTH(DEPTH)) bus1 ();

   uart_rx_os #(.WIDTH(W), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
      .clk_rx (clk_rx),
      .reset  (reset),
      .bus    (bus)
   );

   uart_rx_os #(.WIDTH(W), .OVERSAMPLE(1), .FIFO_DEPTH(DEPTH)) dut1 (
      .clk_rx (clk_rx),
      .reset  (reset),
      .bus    (bus1)
   );

   logic [W-1:0] exp_q [$];
   int n_chk = 0, n_pass = 0;
   int exp_ferr = 0, exp_ovf = 0, obs_ferr = 0, obs_ovf = 0;
   int obs_ferr1 = 0, obs_ovf1 = 0, obs_valid1 = 0;
   int ready_mode = 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic parity_flag(input logic [63:0] fr);
      return ($countones(fr) % 2) == 0;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_rx);
         #1;
      end
   endtask

   // glitch_bit >= 0 inverts that data bit for one cycle at its mid-point.
   task automatic send(input logic [63:0] fr, input logic stop, input int glitch_bit);
      bus.rx_in = 1'b0;
      tick(OS);
      for (int i = 0; i < W; i++) begin
         if (i == glitch_bit) begin
            bus.rx_in = fr[i];
            tick(OS / 2);
            bus.rx_in = ~fr[i];
            tick(1);
            bus.rx_in = fr[i];
            tick(OS - OS / 2 - 1);
         end else begin
            bus.rx_in = fr[i];
            tick(OS);
         end
      end
      if (stop) begin
         if (exp_q.size() < DEPTH) exp_q.push_back({parity_flag(fr), fr[W-2:0]});
         else exp_ovf++;
      end else begin
         exp_ferr++;
      end
      bus.rx_in = stop;
      tick(OS);
      bus.rx_in = 1'b1;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.rx_valid) && n < 3000) begin
         tick(1);
         n++;
      end
      chk("drain timeout", n >= 3000, 1'b0);
   endtask

   // Consumer ready driver.
   initial begin
      bus.rx_ready = 1'b0;
      forever begin
         @(posedge clk_rx);
         #1;
         case (ready_mode)
            0:       bus.rx_ready = 1'b0;
            1:       bus.rx_ready = 1'b1;
            default: bus.rx_ready = ($urandom_range(3) != 0);
         endcase
      end
   end

   // Scoreboard monitor and pulse counters.
   always @(negedge clk_rx) begin
      if (!reset) begin
         if (bus.framing_error)  obs_ferr++;
         if (bus.overflow)       obs_ovf++;
         if (bus1.framing_error) obs_ferr1++;
         if (bus1.overflow)      obs_ovf1++;
         if (bus1.rx_valid)      obs_valid1++;
         if (bus.rx_valid && bus.rx_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious valid", bus.rx_valid, 1'b0);
            end else begin
               logic [W-1:0] e;
               e = exp_q.pop_front();
               chk("rx_data", bus.rx_data, e[W-2:0]);
               chk("parity_error", bus.parity_error, e[W-1]);
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] fr;
      logic        stop;
      int          n;
      bus.rx_in   = 1'b1;
      bus1.rx_in  = 1'b1;
      bus1.rx_ready = 1'b1;
      reset = 1'b1;
      tick(4);
      chk("reset rx_valid", bus.rx_valid, 1'b0);
      chk("reset rx_data", bus.rx_data, '0);
      chk("reset parity_error", bus.parity_error, 1'b0);
      chk("reset framing_error", bus.framing_error, 1'b0);
      chk("reset overflow", bus.overflow, 1'b0);
      chk("reset fifo_count", bus.fifo_count, '0);
      reset = 1'b0;
      tick(3);

      // Directed frames with good and bad parity.
      send(64'h8123456789ABCDEF, 1'b1, -1);
      wait_drain();
      send(64'h0123456789ABCDEF, 1'b1, -1);
      wait_drain();

      // Stop bit low: frame dropped, next frame still received.
      send(64'h0F0F_1234_5678_9ABC, 1'b0, -1);
      tick(OS * 4);
      chk("fifo_count after framing err", bus.fifo_count, '0);
      chk("framing_error pulses", obs_ferr, exp_ferr);
      send(64'h5A5A_A5A5_0FF0_C3C3, 1'b1, -1);
      wait_drain();

      // Five back-to-back frames with consumer stalled.
      ready_mode = 0;
      tick(2);
      for (int i = 0; i < 5; i++) send({$urandom, $urandom}, 1'b1, -1);
      tick(OS * 3);
      chk("fifo_count full", bus.fifo_count, DEPTH);
      chk("overflow pulses", obs_ovf, exp_ovf);
      chk("overflow expected once", exp_ovf, 1);
      ready_mode = 1;
      wait_drain();
      tick(2);
      chk("rx_valid after drain", bus.rx_valid, 1'b0);

      // One-cycle glitch on an idle line.
      bus.rx_in = 1'b0;
      tick(1);
      bus.rx_in = 1'b1;
      tick(20);
      chk("glitch fifo_count", bus.fifo_count, '0);
      chk("glitch framing_error", obs_ferr, exp_ferr);
      chk("glitch overflow", obs_ovf, exp_ovf);

`ifdef UART_RX_MAJORITY_EN
      send(64'h8123456789ABCDEF, 1'b1, 5);
      wait_drain();
`endif

      // Random frames, gaps and stop errors with a randomly stalling consumer.
      ready_mode = 2;
      for (int k = 0; k < 10; k++) begin
         fr   = {$urandom, $urandom};
         stop = ($urandom_range(4) != 0);
         send(fr, stop, -1);
         tick((stop ? $urandom_range(2) : 2) * OS);
      end
      ready_mode = 1;
      wait_drain();
      tick(4);
      chk("random framing_error pulses", obs_ferr, exp_ferr);
      chk("random overflow pulses", obs_ovf, exp_ovf);

      // OVERSAMPLE=1 receiver: one full frame.
      bus1.rx_in = 1'b0;
      tick(1);
      fr = 64'h8000_0000_0000_0000;
      for (int i = 0; i < W; i++) begin
         bus1.rx_in = fr[i];
         tick(1);
      end
      bus1.rx_in = 1'b1;
      n = 0;
      while (!bus1.rx_valid && n < 200) begin
         tick(1);
         n++;
      end
      chk("os1 valid timeout", n >= 200, 1'b0);
      chk("os1 rx_data", bus1.rx_data, '0);
      chk("os1 parity_error", bus1.parity_error, 1'b0);
      tick(4);

      // Reset in the middle of a second frame.
      fr = 64'hFFFF_FFFF_FFFF_0000;
      bus1.rx_in = 1'b0;
      tick(1);
      for (int i = 0; i < 20; i++) begin
         bus1.rx_in = fr[i];
         tick(1);
      end
      bus1.rx_in = 1'b1;
      reset = 1'b1;
      tick(2);
      chk("os1 reset rx_valid", bus1.rx_valid, 1'b0);
      chk("os1 reset rx_data", bus1.rx_data, '0);
      chk("os1 reset fifo_count", bus1.fifo_count, '0);
      chk("os1 reset framing_error", bus1.framing_error, 1'b0);
      chk("os1 reset overflow", bus1.overflow, 1'b0);
      reset = 1'b0;
      tick(100);
      chk("os1 post-reset fifo_count", bus1.fifo_count, '0);
      chk("os1 valid cycles", obs_valid1, 1);
      chk("os1 framing pulses", obs_ferr1, 0);
      chk("os1 overflow pulses", obs_ovf1, 0);
      chk("main post-reset rx_valid", bus.rx_valid, 1'b0);
      chk("leftover expected words", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
